// File: rtl/rgb_load_seq_if.sv
// Color offer / PWM load bus between an upstream color source and rgb_load_seq.
// SIZE must match the SIZE of the rgb_load_seq instance it connects to.
interface rgb_load_seq_if #(
  parameter int SIZE = 13
);
  logic            color_valid;
  logic [7:0]      color_r;
  logic [7:0]      color_g;
  logic [7:0]      color_b;
  logic            color_ready;
  logic [SIZE-1:0] duty;
  logic            load_r;
  logic            load_g;
  logic            load_b;
  logic            busy;

  modport master (
    output color_valid, color_r, color_g, color_b,
    input  color_ready, duty, load_r, load_g, load_b, busy
  );

  modport slave (
    input  color_valid, color_r, color_g, color_b,
    output color_ready, duty, load_r, load_g, load_b, busy
  );
endinterface

// File: rtl/rgb_load_seq.sv
// Accepts one RGB color, strobes it into three PWM channels one per cycle, then idles HOLD_CYCLES.
// Optional macro RGB_LOAD_SEQ_GAMMA_EN selects square-law scaling instead of bit replication.
module rgb_load_seq #(
    parameter int SIZE        = 13,
    parameter int HOLD_CYCLES = 8192
) (
    input logic          sys_clk,
    input logic          rst,
    rgb_load_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_R,
        LOAD_G,
        LOAD_B,
        HOLD
    } state_t;

    localparam int            CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES);
`ifndef RGB_LOAD_SEQ_GAMMA_EN
    localparam int            EXT       = SIZE - 8;
`endif

    state_t          state_q, state_n;
    logic [CW-1:0]   hold_cnt_q, hold_cnt_n;
    logic [7:0]      cap_r_q, cap_g_q, cap_b_q;
    logic            ready_q;
    logic            load_r_q, load_g_q, load_b_q;
    logic [SIZE-1:0] duty_q, duty_n;
    logic            accept;
    logic [7:0]      chan;

    function automatic logic [SIZE-1:0] scale(input logic [7:0] c);
`ifdef RGB_LOAD_SEQ_GAMMA_EN
        logic [15:0] p;
        p = 16'(c) * 16'(c);
        return p[15 -: SIZE];
`else
        return {c, c[7 -: EXT]};
`endif
    endfunction

    always_comb begin
        accept     = bus.color_valid && ready_q && (state_q == IDLE);
        state_n    = state_q;
        hold_cnt_n = hold_cnt_q;
        case (state_q)
            IDLE:   if (accept) state_n = LOAD_R;
            LOAD_R: state_n = LOAD_G;
            LOAD_G: state_n = LOAD_B;
            LOAD_B: begin
                state_n    = HOLD;
                hold_cnt_n = HOLD_LOAD;
            end
            HOLD: begin
                if (hold_cnt_q != '0) hold_cnt_n = hold_cnt_q - CW'(1);
                if (hold_cnt_q <= CW'(1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Red is forwarded from the inputs on the handshake edge so duty lines up with load_r.
    always_comb begin
        duty_n = duty_q;
        case (state_n)
            LOAD_R:  chan = accept ? bus.color_r : cap_r_q;
            LOAD_G:  chan = cap_g_q;
            default: chan = cap_b_q;
        endcase
        if (state_n == LOAD_R || state_n == LOAD_G || state_n == LOAD_B)
            duty_n = scale(chan);
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            hold_cnt_q <= '0;
            cap_r_q    <= '0;
            cap_g_q    <= '0;
            cap_b_q    <= '0;
            ready_q    <= 1'b0;
            load_r_q   <= 1'b0;
            load_g_q   <= 1'b0;
            load_b_q   <= 1'b0;
            duty_q     <= '0;
        end else begin
            state_q    <= state_n;
            hold_cnt_q <= hold_cnt_n;
            ready_q    <= (state_n == IDLE);
            load_r_q   <= (state_n == LOAD_R);
            load_g_q   <= (state_n == LOAD_G);
            load_b_q   <= (state_n == LOAD_B);
            duty_q     <= duty_n;
            if (accept) begin
                cap_r_q <= bus.color_r;
                cap_g_q <= bus.color_g;
                cap_b_q <= bus.color_b;
            end
        end
    end

    assign bus.color_ready = ready_q;
    assign bus.load_r      = load_r_q;
    assign bus.load_g      = load_g_q;
    assign bus.load_b      = load_b_q;
    assign bus.duty        = duty_q;
    assign bus.busy        = (state_q != IDLE);

    a_one_strobe: assert property (@(posedge sys_clk) disable iff (rst)
        $onehot0({load_r_q, load_g_q, load_b_q}));
    a_ready_idle: assert property (@(posedge sys_clk) disable iff (rst)
        ready_q |-> (state_q == IDLE));
    a_cnt_range:  assert property (@(posedge sys_clk) disable iff (rst)
        hold_cnt_q <= HOLD_LOAD);

endmodule

// File: tb/tb_rgb_load_seq.sv
// Directed bench for rgb_load_seq (SIZE=13, HOLD_CYCLES=4); expected duties hand-computed per build.
module tb_rgb_load_seq;

    logic sys_clk;
    logic rst;
    int   total;
    int   bad;

    rgb_load_seq_if #(.SIZE(13)) bus ();

    rgb_load_seq #(.SIZE(13), .HOLD_CYCLES(4)) dut (
        .sys_clk (sys_clk),
        .rst     (rst),
        .bus     (bus)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

`ifdef RGB_LOAD_SEQ_GAMMA_EN
    localparam logic [12:0] E1R = 13'h1FC0, E1G = 13'h0800, E1B = 13'h0000;
    localparam logic [12:0] E2R = 13'h03F4, E2G = 13'h1291, E2B = 13'h0000;
`else
    localparam logic [12:0] E1R = 13'h1FFF, E1G = 13'h1010, E1B = 13'h0000;
    localparam logic [12:0] E2R = 13'h0B4B, E2G = 13'h1878, E2B = 13'h0020;
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] loads();
        return {bus.load_r, bus.load_g, bus.load_b};
    endfunction

    task automatic wait_ready(input string tag);
        int unsigned n;
        n = 0;
        while (bus.color_ready !== 1'b1 && n < 50) begin
            @(negedge sys_clk);
            n++;
        end
        check(tag, 32'(bus.color_ready), 32'd1);
    endtask

    task automatic send_color(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                              input logic [12:0] er, input logic [12:0] eg, input logic [12:0] eb,
                              input bit poke_hold, input string tag);
        wait_ready({tag, "_rdy"});
        bus.color_valid = 1'b1;
        bus.color_r = r;
        bus.color_g = g;
        bus.color_b = b;
        @(negedge sys_clk);
        bus.color_valid = 1'b0;
        check({tag, "_lr"},   32'(loads()), 32'b100);
        check({tag, "_dr"},   32'(bus.duty), 32'(er));
        check({tag, "_bsy"},  32'({bus.busy, bus.color_ready}), 32'b10);
        @(negedge sys_clk);
        check({tag, "_lg"},   32'(loads()), 32'b010);
        check({tag, "_dg"},   32'(bus.duty), 32'(eg));
        @(negedge sys_clk);
        check({tag, "_lb"},   32'(loads()), 32'b001);
        check({tag, "_db"},   32'(bus.duty), 32'(eb));
        for (int k = 0; k < 4; k++) begin
            if (poke_hold && k == 1) begin
                bus.color_valid = 1'b1;
                bus.color_r = 8'h11;
                bus.color_g = 8'h22;
                bus.color_b = 8'h33;
            end else begin
                bus.color_valid = 1'b0;
            end
            @(negedge sys_clk);
            check({tag, "_hold"}, 32'({loads(), bus.color_ready, bus.busy}), 32'b00001);
            check({tag, "_hdty"}, 32'(bus.duty), 32'(eb));
        end
        bus.color_valid = 1'b0;
        @(negedge sys_clk);
        check({tag, "_idle"}, 32'({loads(), bus.color_ready, bus.busy}), 32'b00010);
        check({tag, "_idty"}, 32'(bus.duty), 32'(eb));
    endtask

    initial begin
        logic [2:0]  seen;
        logic        seen_busy;
        logic        seen_duty;
        int unsigned n;
        int unsigned low;

        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.color_valid = 1'b0;
        bus.color_r = '0;
        bus.color_g = '0;
        bus.color_b = '0;

        repeat (3) @(negedge sys_clk);
        check("rst_loads", 32'(loads()), 32'd0);
        check("rst_busy",  32'(bus.busy), 32'd0);
        check("rst_duty",  32'(bus.duty), 32'd0);
        rst = 1'b0;
        @(negedge sys_clk);
        check("rdy_after_rst", 32'(bus.color_ready), 32'd1);

        seen = '0;
        seen_busy = 1'b0;
        seen_duty = 1'b0;
        repeat (100) begin
            @(negedge sys_clk);
            seen |= loads();
            seen_busy |= bus.busy;
            seen_duty |= (bus.duty != '0);
        end
        check("idle_loads", 32'(seen), 32'd0);
        check("idle_busy",  32'(seen_busy), 32'd0);
        check("idle_duty",  32'(seen_duty), 32'd0);

        send_color(8'hFF, 8'h80, 8'h00, E1R, E1G, E1B, 1'b0, "v1");
        send_color(8'h5A, 8'hC3, 8'h01, E2R, E2G, E2B, 1'b1, "v2");

        seen = '0;
        repeat (3) begin
            @(negedge sys_clk);
            seen |= loads();
        end
        check("poke_noload", 32'(seen), 32'd0);
        check("poke_duty",   32'(bus.duty), 32'(E2B));

        // Back-to-back: valid held high, colors changed while busy.
        wait_ready("b2b_rdy");
        bus.color_valid = 1'b1;
        bus.color_r = 8'hFF;
        bus.color_g = 8'h80;
        bus.color_b = 8'h00;
        @(negedge sys_clk);
        check("b2b_first", 32'(loads()), 32'b100);
        check("b2b_d1r",   32'(bus.duty), 32'(E1R));
        bus.color_r = 8'h5A;
        bus.color_g = 8'hC3;
        bus.color_b = 8'h01;
        low = (bus.color_ready == 1'b0) ? 1 : 0;
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
            if (n == 1) check("b2b_d1g", 32'(bus.duty), 32'(E1G));
            if (!bus.load_r && !bus.color_ready) low++;
        end while (!bus.load_r && n < 40);
        bus.color_valid = 1'b0;
        check("b2b_gap",   n, 32'd8);
        check("b2b_low",   low, 32'd7);
        check("b2b_d2r",   32'(bus.duty), 32'(E2R));
        @(negedge sys_clk);
        check("b2b_d2g",   32'(bus.duty), 32'(E2G));
        @(negedge sys_clk);
        check("b2b_d2b",   32'(bus.duty), 32'(E2B));

        // Reset while in LOAD_G.
        wait_ready("ab_rdy");
        bus.color_valid = 1'b1;
        bus.color_r = 8'h5A;
        bus.color_g = 8'hC3;
        bus.color_b = 8'h01;
        @(negedge sys_clk);
        bus.color_valid = 1'b0;
        @(negedge sys_clk);
        check("ab_lg", 32'(loads()), 32'b010);
        #2 rst = 1'b1;
        #1;
        check("ab_async_loads", 32'(loads()), 32'd0);
        check("ab_async_duty",  32'(bus.duty), 32'd0);
        check("ab_async_busy",  32'(bus.busy), 32'd0);
        @(negedge sys_clk);
        @(negedge sys_clk);
        rst = 1'b0;
        seen = '0;
        @(negedge sys_clk);
        check("ab_rdy_after", 32'(bus.color_ready), 32'd1);
        seen |= loads();
        repeat (4) begin
            @(negedge sys_clk);
            seen |= loads();
        end
        check("ab_no_loadb", 32'(seen), 32'd0);
        check("ab_duty",     32'(bus.duty), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
